// File: rtl/bus_xcvr_ctrl.sv
// Sequencer for a 74x245-style bus transceiver: turns single read/write requests
// into ordered DIR/nOE control and device strobes with a guarded direction turnaround.
module bus_xcvr_ctrl #(
    parameter int WIDTH         = 8,
    parameter int ACCESS_CYCLES = 2,
    parameter int TURN_CYCLES   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [WIDTH-1:0] req_wdata,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_rdata,
    output logic             xcvr_dir,
    output logic             xcvr_noe,
    output logic [WIDTH-1:0] a_out,
    output logic             a_out_en,
    input  logic [WIDTH-1:0] a_in,
    output logic             dev_nrd,
    output logic             dev_nwr,
    output logic [1:0]       dbg_state
);

    localparam int MAX_CYC = (ACCESS_CYCLES > TURN_CYCLES) ? ACCESS_CYCLES : TURN_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_TURN   = 2'd1,
        S_ACCESS = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            wr_q;
    logic            dir_q;
    logic            noe_q;
    logic            nrd_q;
    logic            nwr_q;
    logic            rsp_valid_q;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] aout_q;

    // Handshake: a request transfers on a rising edge where req_valid & req_ready;
    // req_ready is high only in IDLE and never while rst is asserted.
    assign req_ready = (state_q == S_IDLE) && !rst;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign xcvr_dir  = dir_q;
    assign a_out_en  = dir_q;
    assign xcvr_noe  = noe_q;
    assign a_out     = aout_q;
    assign dev_nrd   = nrd_q;
    assign dev_nwr   = nwr_q;
    assign dbg_state = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            wr_q        <= 1'b0;
            dir_q       <= 1'b0;
            noe_q       <= 1'b1;
            nrd_q       <= 1'b1;
            nwr_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            aout_q      <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        wr_q   <= req_write;
                        aout_q <= req_wdata;
                        // Direction flips only here, while nOE is already high.
                        if (req_write != dir_q) begin
                            state_q <= S_TURN;
                            dir_q   <= req_write;
                            cnt_q   <= CW'(TURN_CYCLES - 1);
                        end else begin
                            state_q <= S_ACCESS;
                            noe_q   <= 1'b0;
                            nwr_q   <= ~req_write;
                            nrd_q   <= req_write;
                            cnt_q   <= CW'(ACCESS_CYCLES - 1);
                        end
                    end
                end
                S_TURN: begin
                    if (cnt_q == '0) begin
                        state_q <= S_ACCESS;
                        noe_q   <= 1'b0;
                        nwr_q   <= ~wr_q;
                        nrd_q   <= wr_q;
                        cnt_q   <= CW'(ACCESS_CYCLES - 1);
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_ACCESS: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_HOLD;
                        nrd_q       <= 1'b1;
                        nwr_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        if (!wr_q) begin
                            rdata_q <= a_in;
                        end
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_HOLD: begin
                    // nOE stayed low through this cycle so write data outlives nWR.
                    state_q <= S_IDLE;
                    noe_q   <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    noe_q   <= 1'b1;
                    nrd_q   <= 1'b1;
                    nwr_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_xcvr_ctrl.sv
// Bench for bus_xcvr_ctrl: transaction-timeline model checked every cycle,
// directed scenarios with literal expectations, then a random request run.
module tb_bus_xcvr_ctrl;

    localparam int W  = 8;
    localparam int AC = 2;
    localparam int TC = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req_valid = 1'b0;
    logic         req_write = 1'b0;
    logic [W-1:0] req_wdata = '0;
    logic [W-1:0] a_in = '0;
    logic         req_ready;
    logic         rsp_valid;
    logic [W-1:0] rsp_rdata;
    logic         xcvr_dir;
    logic         xcvr_noe;
    logic [W-1:0] a_out;
    logic         a_out_en;
    logic         dev_nrd;
    logic         dev_nwr;
    logic [1:0]   dbg_state;

    bus_xcvr_ctrl #(.WIDTH(W), .ACCESS_CYCLES(AC), .TURN_CYCLES(TC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .xcvr_dir(xcvr_dir), .xcvr_noe(xcvr_noe),
        .a_out(a_out), .a_out_en(a_out_en), .a_in(a_in),
        .dev_nrd(dev_nrd), .dev_nwr(dev_nwr),
        .dbg_state(dbg_state)
    );

    initial forever #5 clk = ~clk;

    // Model: a transaction accepted at cycle t is described only by k = cycles
    // since acceptance; TURN spans k=1..T, ACCESS the next AC cycles, then HOLD.
    logic         m_active = 1'b0;
    int           m_k = 0;
    int           m_t = 0;
    logic         m_wr = 1'b0;
    logic         m_dir = 1'b0;
    logic [W-1:0] m_aout = '0;
    logic [W-1:0] m_rdata = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_dir    <= 1'b0;
            m_aout   <= '0;
            m_rdata  <= '0;
        end else if (m_active) begin
            if (m_k == m_t + AC && !m_wr) m_rdata <= a_in;
            if (m_k == m_t + AC + 1) m_active <= 1'b0;
            else m_k <= m_k + 1;
        end else if (req_valid) begin
            m_active <= 1'b1;
            m_k      <= 1;
            m_t      <= (req_write != m_dir) ? TC : 0;
            m_wr     <= req_write;
            m_aout   <= req_wdata;
            m_dir    <= req_write;
        end
    end

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_acc = 0;
    int   n_rsp = 0;
    logic last_ready = 1'b0;
    logic last_acc = 1'b0;
    logic prev_dir = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to the next falling edge and compare every output with the model.
    task automatic cycle();
        logic in_acc, in_hold;
        last_acc = req_valid && last_ready && !rst;
        if (last_acc) n_acc++;
        @(negedge clk);
        in_acc  = m_active && (m_k > m_t) && (m_k <= m_t + AC);
        in_hold = m_active && (m_k == m_t + AC + 1);
        chk("m_ready",     32'(req_ready), 32'(!m_active && !rst));
        chk("m_noe",       32'(xcvr_noe),  32'(!(in_acc || in_hold)));
        chk("m_dir",       32'(xcvr_dir),  32'(m_dir));
        chk("m_aout_en",   32'(a_out_en),  32'(m_dir));
        chk("m_nrd",       32'(dev_nrd),   32'(!(in_acc && !m_wr)));
        chk("m_nwr",       32'(dev_nwr),   32'(!(in_acc && m_wr)));
        chk("m_rsp_valid", 32'(rsp_valid), 32'(in_hold));
        chk("m_rdata",     32'(rsp_rdata), 32'(m_rdata));
        chk("m_aout",      32'(a_out),     32'(m_aout));
        chk("inv_strobe_overlap", 32'(!dev_nrd && !dev_nwr), 0);
        chk("inv_strobe_no_oe",   32'((!dev_nrd || !dev_nwr) && xcvr_noe), 0);
        chk("inv_dir_while_oe",   32'((xcvr_dir != prev_dir) && !xcvr_noe), 0);
        prev_dir   = xcvr_dir;
        last_ready = req_ready;
        if (rsp_valid) n_rsp++;
    endtask

    initial begin
        int acc0, rsp0, n, gap;
        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'hFF;
        repeat (3) begin
            cycle();
            chk("rst_noe", 32'(xcvr_noe), 1);
            chk("rst_dir", 32'(xcvr_dir), 0);
            chk("rst_nrd", 32'(dev_nrd), 1);
            chk("rst_nwr", 32'(dev_nwr), 1);
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_rsp_valid", 32'(rsp_valid), 0);
            chk("rst_state_idle", 32'(dbg_state), 0);
        end
        #1 rst = 1'b0; req_valid = 1'b0;
        cycle();
        chk("ready_after_rst", 32'(req_ready), 1);

        // Read after reset: no turnaround.
        #1 req_valid = 1'b1; req_write = 1'b0; req_wdata = 8'h00; a_in = 8'hA5;
        cycle(); chk("rd_t1_nrd", 32'(dev_nrd), 0); chk("rd_t1_noe", 32'(xcvr_noe), 0);
        #1 req_valid = 1'b0;
        cycle(); chk("rd_t2_nrd", 32'(dev_nrd), 0);
        cycle(); chk("rd_t3_nrd", 32'(dev_nrd), 1); chk("rd_t3_rsp", 32'(rsp_valid), 1);
        chk("rd_t3_rdata", 32'(rsp_rdata), 32'h A5);
        cycle(); chk("rd_t4_ready", 32'(req_ready), 1); chk("rd_t4_rsp", 32'(rsp_valid), 0);

        // Write 0x3C after the read: one TURN cycle.
        #1 req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'h3C; a_in = 8'h00;
        cycle(); chk("wr_turn_noe", 32'(xcvr_noe), 1); chk("wr_turn_dir", 32'(xcvr_dir), 1);
        chk("wr_turn_nwr", 32'(dev_nwr), 1);
        #1 req_valid = 1'b0;
        cycle(); chk("wr_t2_nwr", 32'(dev_nwr), 0); chk("wr_t2_aout", 32'(a_out), 32'h3C);
        cycle(); chk("wr_t3_nwr", 32'(dev_nwr), 0);
        cycle(); chk("wr_t4_nwr", 32'(dev_nwr), 1); chk("wr_t4_rsp", 32'(rsp_valid), 1);
        chk("wr_t4_aout", 32'(a_out), 32'h3C); chk("wr_t4_noe", 32'(xcvr_noe), 0);
        cycle(); chk("wr_t5_ready", 32'(req_ready), 1);

        // Back-to-back writes with req_valid held high.
        #1 req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'h11;
        cycle(); chk("b2b_1_nwr", 32'(dev_nwr), 0); chk("b2b_1_aout", 32'(a_out), 32'h11);
        cycle(); cycle();
        cycle(); chk("b2b_second_ready", 32'(req_ready), 1);
        #1 req_wdata = 8'h22;
        cycle(); chk("b2b_2_nwr", 32'(dev_nwr), 0); chk("b2b_2_aout", 32'(a_out), 32'h22);
        chk("b2b_rdata_kept", 32'(rsp_rdata), 32'h A5);
        #1 req_valid = 1'b0;
        cycle();
        cycle(); chk("b2b_2_rsp", 32'(rsp_valid), 1);
        cycle(); chk("b2b_done_ready", 32'(req_ready), 1);

        // Reset during the second ACCESS cycle of a write.
        #1 req_valid = 1'b1; req_write = 1'b1; req_wdata = 8'h5A;
        cycle(); chk("rmw_t1_nwr", 32'(dev_nwr), 0);
        #1 req_valid = 1'b0;
        cycle(); chk("rmw_t2_nwr", 32'(dev_nwr), 0);
        #1 rst = 1'b1;
        cycle(); chk("rmw_nwr", 32'(dev_nwr), 1); chk("rmw_noe", 32'(xcvr_noe), 1);
        chk("rmw_rsp", 32'(rsp_valid), 0); chk("rmw_aout", 32'(a_out), 0);
        #1 rst = 1'b0;
        cycle(); chk("rmw_after_rsp", 32'(rsp_valid), 0); chk("rmw_after_ready", 32'(req_ready), 1);

        // Random requests with random a_in and idle gaps.
        acc0 = n_acc;
        rsp0 = n_rsp;
        for (int i = 0; i < 1000; i++) begin
            #1;
            req_valid = 1'b1;
            req_write = 1'($urandom_range(0, 1));
            req_wdata = W'($urandom_range(0, 255));
            a_in      = W'($urandom_range(0, 255));
            n = 0;
            do begin
                cycle();
                n++;
                if (!last_acc) begin
                    #1 a_in = W'($urandom_range(0, 255));
                end
            end while (!last_acc && n < 40);
            if (!last_acc) chk("accept_timeout", 32'(last_acc), 1);
            #1 req_valid = 1'b0;
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                cycle();
                #1 a_in = W'($urandom_range(0, 255));
            end
        end
        repeat (8) cycle();
        chk("rsp_count_vs_accept", 32'(n_rsp - rsp0), 32'(n_acc - acc0));
        chk("random_accept_count", 32'(n_acc - acc0), 1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
